// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - UART transmitter for the free-running counter byte
// Start, 8 data bits LSB-first, optional parity, one stop bit; tx is registered.
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic           PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam logic           PAR_ODD  = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    shift, shift_d;
  logic [2:0]    idx, idx_d;
  logic          par, par_d;
  logic          tx_d;
  logic          bit_end;

  assign bit_end  = (cnt == CNT_LAST);
  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      shift <= '0;
      idx   <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      shift <= shift_d;
      idx   <= idx_d;
      par   <= par_d;
      tx    <= tx_d;
    end
  end

  // tx_d is the level for the bit selected by the current state/counter;
  // registering it delays every bit uniformly by one cycle.
  always_comb begin
    state_d = state;
    cnt_d   = bit_end ? '0 : cnt + CW'(1);
    shift_d = shift;
    idx_d   = idx;
    par_d   = par;
    tx_d    = 1'b1;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          shift_d = in_data;
          par_d   = (^in_data) ^ PAR_ODD;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = shift[0];
        if (bit_end) begin
          shift_d = {1'b0, shift[7:1]};
          idx_d   = idx + 3'd1;
          if (idx == 3'd7) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_d = par;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// tb/tb_count_uart_tx.sv - directed vector bench for count_uart_tx
// Four instances cover no/even/odd parity at 4 clocks per bit and the 2-clock minimum.
module tb_count_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic [3:0] vld = 4'h0;
  logic [3:0] rdy;
  logic [3:0] txv;
  logic [3:0] bsy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  count_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[0]),
    .in_ready(rdy[0]), .tx(txv[0]), .busy(bsy[0]));
  count_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[1]),
    .in_ready(rdy[1]), .tx(txv[1]), .busy(bsy[1]));
  count_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[2]),
    .in_ready(rdy[2]), .tx(txv[2]), .busy(bsy[2]));
  count_uart_tx #(.CLKS_PER_BIT(2), .PARITY(0)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[3]),
    .in_ready(rdy[3]), .tx(txv[3]), .busy(bsy[3]));

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [10:0] exp_bits;
    int          nbits;
    string       name;
  } vec_t;

  vec_t vecs[9];

  function automatic int cpb_of(input int s);
    return (s == 3) ? 2 : 4;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Sends one byte and compares tx/busy/in_ready every cycle against the
  // hand-written bit pattern; also decodes the data bits mid-bit like a receiver.
  task automatic run_frame(input int sel, input logic [7:0] d, input logic [10:0] eb,
                           input int nb, input string nm);
    int   cpb, len, tx_err, bsy_err, rdy_err, first_bad;
    logic exp_t, exp_b;
    logic wf [64];
    logic [7:0] rxd;
    cpb = cpb_of(sel);
    len = nb * cpb;
    tx_err = 0; bsy_err = 0; rdy_err = 0; first_bad = -1;
    @(negedge clk);
    in_data  = d;
    vld[sel] = 1'b1;
    for (int c = 1; c <= len + 2; c++) begin
      @(negedge clk);
      if (c == 1) vld[sel] = 1'b0;
      exp_t = 1'b1;
      if (c >= 2 && c <= len + 1) exp_t = eb[(c - 2) / cpb];
      exp_b = (c <= len);
      wf[c] = txv[sel];
      if (txv[sel] !== exp_t) begin
        tx_err++;
        if (first_bad < 0) first_bad = c;
      end
      if (bsy[sel] !== exp_b) bsy_err++;
      if (rdy[sel] !== !exp_b) rdy_err++;
    end
    for (int k = 0; k < 8; k++) rxd[k] = wf[2 + (k + 1) * cpb + cpb / 2];
    if (tx_err != 0) $display("  %s: first bad tx cycle %0d", nm, first_bad);
    check({nm, "_tx_bad_cycles"}, tx_err, 0);
    check({nm, "_busy_bad_cycles"}, bsy_err, 0);
    check({nm, "_ready_bad_cycles"}, rdy_err, 0);
    check({nm, "_rx_data"}, int'(rxd), int'(d));
  endtask

  task automatic rx_frame(input int sel, input int cpb, output logic [7:0] b, output int st);
    int w, pos, target;
    b = 8'h00;
    w = 0;
    st = -1;
    do begin
      @(negedge clk);
      w++;
    end while (txv[sel] !== 1'b0 && w < 500);
    if (w >= 500) begin
      check("rx_start_timeout", 1, 0);
      return;
    end
    st  = cyc;
    pos = 0;
    for (int k = 0; k < 9; k++) begin
      target = (k + 1) * cpb + cpb / 2;
      while (pos < target) begin
        @(negedge clk);
        pos++;
      end
      if (k < 8) b[k] = txv[sel];
      else check("rx_stop_bit", int'(txv[sel]), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         starts[3];
    logic [7:0] got[3];
    int         bad;

    vecs[0] = '{0, 8'hA5, 11'b0_1_10100101_0, 10, "a5_none"};
    vecs[1] = '{1, 8'h07, 11'b1_1_00000111_0, 11, "07_even"};
    vecs[2] = '{2, 8'h07, 11'b1_0_00000111_0, 11, "07_odd"};
    vecs[3] = '{1, 8'h00, 11'b1_0_00000000_0, 11, "00_even"};
    vecs[4] = '{2, 8'hFF, 11'b1_1_11111111_0, 11, "ff_odd"};
    vecs[5] = '{1, 8'h80, 11'b1_1_10000000_0, 11, "80_even"};
    vecs[6] = '{0, 8'h00, 11'b0_1_00000000_0, 10, "00_none"};
    vecs[7] = '{3, 8'h3C, 11'b0_1_00111100_0, 10, "3c_cpb2"};
    vecs[8] = '{3, 8'hC3, 11'b0_1_11000011_0, 10, "c3_cpb2"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_tx", int'(txv), 4'hF);
    check("reset_busy", int'(bsy), 4'h0);
    check("reset_ready", int'(rdy), 4'hF);

    for (int i = 0; i < 9; i++)
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].exp_bits, vecs[i].nbits, vecs[i].name);

    // Back-to-back with incrementing data: captures land 41 cycles apart.
    @(negedge clk);
    in_data = 8'h00;
    vld[0]  = 1'b1;
    fork
      begin
        for (int i = 1; i <= 120; i++) begin
          @(negedge clk);
          in_data = in_data + 8'd1;
        end
        vld[0] = 1'b0;
      end
      begin
        for (int f = 0; f < 3; f++) rx_frame(0, 4, got[f], starts[f]);
      end
    join
    check("b2b_byte0", int'(got[0]), 8'h00);
    check("b2b_byte1", int'(got[1]), 8'h29);
    check("b2b_byte2", int'(got[2]), 8'h52);
    check("b2b_spacing01", starts[1] - starts[0], 41);
    check("b2b_spacing12", starts[2] - starts[1], 41);
    repeat (5) @(negedge clk);
    check("b2b_no_extra_busy", int'(bsy[0]), 0);
    check("b2b_line_idle", int'(txv[0]), 1);

    // Reset during data bit 3 of a 0x00 frame.
    @(negedge clk);
    in_data = 8'h00;
    vld[0]  = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("midrst_pre_tx_low", int'(txv[0]), 0);
    check("midrst_pre_busy", int'(bsy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", int'(txv[0]), 1);
    check("midrst_busy", int'(bsy[0]), 0);
    check("midrst_ready", int'(rdy[0]), 1);
    rst = 1'b0;
    run_frame(0, 8'hFF, 11'b0_1_11111111_0, 10, "ff_after_rst");

    // in_valid only while busy must not start a second frame.
    fork
      run_frame(0, 8'h5A, 11'b0_1_01011010_0, 10, "5a_valid_while_busy");
      begin
        repeat (6) @(negedge clk);
        in_data = 8'h33;
        vld[0]  = 1'b1;
        repeat (25) @(negedge clk);
        vld[0] = 1'b0;
      end
    join
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (txv[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
    end
    check("ignored_valid_no_frame", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
Serial output stage for the 8-bit free-running counter value. It accepts one byte per valid/ready handshake and transmits it as an asynchronous UART frame (start, 8 data bits LSB-first, optional parity, 1 stop) on a single output pin. The counter drives `in_data`. The `tx` output goes to one dedicated output pin, so the count can be read by any host UART.

Parameters:
CLKS_PER_BIT, 87, clock cycles per serial bit (10 MHz / 115200 baud); legal range >= 2.
PARITY, 0, 0 = none, 1 = even, 2 = odd; any other value is treated as 0.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  reset; one clock; reset is synchronous and active-high.
in_data  input  8  byte to transmit (counter value).
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept a byte this cycle.
tx  output  1  serial line, idle high.
busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, tx=1, busy=0, in_ready=1 from the next cycle onward. The shift register, bit index and baud counter are all cleared.
- Reset mid-frame: the frame is abandoned. tx returns high on the cycle after the reset edge. No partial byte is resumed.
- States: IDLE, START, DATA, PARITY, STOP.
- in_ready = (state==IDLE). This is combinational from state and does not depend on in_valid.
- Handshake: in_valid && in_ready at a posedge captures in_data into the shift register. At that edge the state moves to START and the baud counter is set to 0. in_data may change freely after capture.
- in_valid while not ready is ignored. No byte is stored; the upstream block must hold the value or drop it.
- The baud counter counts 0..CLKS_PER_BIT-1. Every state except IDLE lasts exactly CLKS_PER_BIT cycles. Its width is clog2(CLKS_PER_BIT).
- START: tx=0. Then DATA.
- DATA: tx = shift[0]. At the end of each bit period the register shifts right and the bit index increments. After bit 7, go to PARITY if PARITY is 1 or 2, otherwise go to STOP.
- PARITY: tx = XOR of the 8 captured bits for even parity, or its inverse for odd parity. The parity is computed from the byte captured at the handshake. Then STOP.
- STOP: tx=1. Then IDLE.
- tx is registered, i.e. glitch-free. It changes only at bit boundaries, one cycle after the state/counter edge that selects the new bit.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT cycles with parity. The frame is measured from the first tx=0 cycle to the end of the stop bit.
- Back-to-back: if in_valid stays high, the next byte is captured in the first IDLE cycle after STOP. This gives exactly 1 idle-high cycle between frames.
- busy=1 from the cycle after capture through the last STOP cycle. It is 0 in IDLE.
- No other outputs exist; all unused internal state is cleared by reset.

Test Plan:
1. CLKS_PER_BIT=4, PARITY=0: reset, then in_data=0xA5 with in_valid pulsed for 1 cycle. Required tx sequence, each bit held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1. in_ready is low for 40 cycles then high, and busy mirrors it.
2. CLKS_PER_BIT=4, PARITY=1, byte 0x07 (three 1 bits): the parity bit is 1. With PARITY=2 the parity bit is 0. The frame is 44 cycles.
3. in_valid held high with in_data incrementing every cycle from 0x00: successive frames carry exactly the values present at each capture edge. Each pair of frames is separated by exactly 1 tx-high cycle, and no byte is captured while busy=1.
4. Assert rst for 1 cycle during DATA bit 3 of a 0x00 frame: tx=1, busy=0 and in_ready=1 on the next cycle. A new byte 0xFF is then sent correctly.
5. in_valid asserted only while busy=1, deasserted before IDLE: no second frame occurs and tx stays high.
6. CLKS_PER_BIT=2 (minimum), byte 0x3C: the frame timing is correct at 2 cycles per bit, and the receiver model in the bench decodes 0x3C.
